// File: rtl/vga_out_stage.sv
// vga_out_stage: VGA timing generator and DAC output register.
// Generates x/y for the upstream layer generators and delays sync/blank by
// PIPE_DLY pixel ticks so that they line up with the muxed rgb_in. The DAC
// outputs lag x/y by PIPE_DLY+1 pixel ticks.
// Optional feature macro: VGA_TEST_PATTERN_EN. It adds a test_mode input that
// replaces rgb_in with eight vertical colour bars.
module vga_out_stage #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_DLY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_en,
`ifdef VGA_TEST_PATTERN_EN
   input  logic        test_mode,
`endif
   input  logic [23:0] rgb_in,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        active,
   output logic        frame_start,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Timing word carried down the delay line: {[x,] hs, vs, blank_n}
`ifdef VGA_TEST_PATTERN_EN
   localparam int TW = 13;
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
`else
   localparam int TW = 3;
`endif
   localparam logic [TW-1:0] TW_RESET = TW'(3'b110);

   logic [9:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic          run_q, run_d;
   logic          active_q, active_d;
   logic          frame_start_q, frame_start_d;
   logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          hs_raw_s, vs_raw_s;
   logic [TW-1:0] raw_s, tap_s;
   logic [23:0]   pixel_s;

`ifdef VGA_TEST_PATTERN_EN
   // Colour of the bar covering column px (anything past bar 6 is black)
   function automatic logic [23:0] bar_colour(input logic [9:0] px);
      logic [9:0] idx;
      idx = px / BAR_W;
      case (idx)
         10'd0:   bar_colour = 24'hFFFFFF;
         10'd1:   bar_colour = 24'hFFFF00;
         10'd2:   bar_colour = 24'h00FFFF;
         10'd3:   bar_colour = 24'h00FF00;
         10'd4:   bar_colour = 24'hFF00FF;
         10'd5:   bar_colour = 24'hFF0000;
         10'd6:   bar_colour = 24'h0000FF;
         default: bar_colour = 24'h000000;
      endcase
   endfunction
`endif

   assign hs_raw_s = ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
   assign vs_raw_s = ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
`ifdef VGA_TEST_PATTERN_EN
   assign raw_s = {h_cnt_q, hs_raw_s, vs_raw_s, active_q};
`else
   assign raw_s = {hs_raw_s, vs_raw_s, active_q};
`endif

   // Scan counters; the first tick after reset (re)starts the frame at (0,0)
   always_comb begin
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      run_d         = run_q;
      active_d      = active_q;
      frame_start_d = 1'b0;
      if (pix_en) begin
         run_d = 1'b1;
         if (!run_q) begin
            h_cnt_d = 10'd0;
            v_cnt_d = 10'd0;
         end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d = 10'd0;
            end else begin
               v_cnt_d = v_cnt_q + 10'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
         active_d      = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
         frame_start_d = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
      end else begin
         frame_start_d = 1'b0;
      end
   end

   generate
      if (PIPE_DLY == 0) begin : g_no_dly
         assign tap_s = raw_s;
      end else begin : g_dly
         logic [TW-1:0] dl_q [PIPE_DLY];
         logic [TW-1:0] dl_d [PIPE_DLY];

         // Shift the raw timing one stage per pixel tick
         always_comb begin
            dl_d[0] = pix_en ? raw_s : dl_q[0];
            for (int i = 1; i < PIPE_DLY; i++) begin
               dl_d[i] = pix_en ? dl_q[i-1] : dl_q[i];
            end
         end

         // Delay line registers, filled with idle sync/blank timing on reset
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < PIPE_DLY; i++) begin
                  dl_q[i] <= TW_RESET;
               end
            end else begin
               for (int i = 0; i < PIPE_DLY; i++) begin
                  dl_q[i] <= dl_d[i];
               end
            end
         end

         assign tap_s = dl_q[PIPE_DLY-1];
      end
   endgenerate

   // Output register: capture pixel and aligned timing, black during blanking
   always_comb begin
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
      rgb_d     = rgb_q;
      pixel_s   = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) begin
         pixel_s = bar_colour(tap_s[12:3]);
      end else begin
         pixel_s = rgb_in;
      end
`endif
      if (pix_en) begin
         hs_d      = tap_s[2];
         vs_d      = tap_s[1];
         blank_n_d = tap_s[0];
         rgb_d     = tap_s[0] ? pixel_s : 24'h000000;
      end else begin
         rgb_d = rgb_q;
      end
   end

   // State registers for counters, flags and the DAC output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         run_q         <= 1'b0;
         active_q      <= 1'b1;
         frame_start_q <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         rgb_q         <= 24'h000000;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         run_q         <= run_d;
         active_q      <= active_d;
         frame_start_q <= frame_start_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         rgb_q         <= rgb_d;
      end
   end

   assign x           = h_cnt_q;
   assign y           = v_cnt_q;
   assign active      = active_q;
   assign frame_start = frame_start_q;
   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_out_stage.sv
// Self-checking bench for vga_out_stage using a reduced raster (25x15) so
// that whole frames run quickly. Expected values come from a linear
// pixel-index model of the scan.
module tb_vga_out_stage;

   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int PD = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_en;
   logic [23:0] rgb_in;
   logic [9:0]  x, y;
   logic        active, frame_start;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;
`ifdef VGA_TEST_PATTERN_EN
   logic        test_mode;
`endif

   vga_out_stage #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(PD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .rgb_in(rgb_in), .x(x), .y(y), .active(active), .frame_start(frame_start),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          pos;        // linear index of the pixel currently on x/y
   bit          started;
   int          hist[$];    // coordinates presented after the last <=4 ticks
   int          ticks;      // ticks since reset
   bit          exp_fs;
   logic [23:0] exp_rgb_raw;
   int          rgb_mode;   // 0: {x,y,A5} delayed 2 ticks, 1: white, 2: random
   int          idle_clks;
   bit          tm_v;
   int          fs_clk_cnt;

   wire [49:0] dut_vec = {x, y, active, frame_start, vga_r, vga_g, vga_b,
                          vga_hs, vga_vs, vga_blank_n, vga_sync_n};

   function automatic bit hs_of(int p);
      int h = p % HT;
      return !((h >= HA + HF) && (h < HA + HF + HS));
   endfunction

   function automatic bit vs_of(int p);
      int v = p / HT;
      return !((v >= VA + VF) && (v < VA + VF + VS));
   endfunction

   function automatic bit vis_of(int p);
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   function automatic logic [23:0] bar_ref(int h);
      logic [23:0] tbl [8];
      tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      return tbl[(h / (HA / 8)) > 7 ? 7 : (h / (HA / 8))];
   endfunction

   function automatic logic [49:0] exp_vec();
      logic [23:0] c;
      bit          ohs, ovs, obl;
      int          p;
      if (ticks < PD + 1) begin
         ohs = 1'b1; ovs = 1'b1; obl = 1'b0; c = 24'h0;
      end else begin
         p   = hist[0];
         ohs = hs_of(p); ovs = vs_of(p); obl = vis_of(p);
         c   = obl ? exp_rgb_raw : 24'h0;
      end
      return {10'(pos % HT), 10'(pos / HT), vis_of(pos), exp_fs, c, ohs, ovs, obl, 1'b0};
   endfunction

   task automatic model_reset();
      pos = 0; started = 1'b0; ticks = 0; exp_fs = 1'b0;
      hist.delete(); hist.push_back(0);
   endtask

   task automatic model_tick(input logic [23:0] drv);
      int p;
      if (!started) begin
         started = 1'b1; exp_fs = 1'b1;
      end else begin
         pos = (pos + 1) % FRAME; exp_fs = (pos == 0);
      end
      hist.push_back(pos);
      if (hist.size() > PD + 2) void'(hist.pop_front());
      ticks++;
      p = hist[0];
      if (tm_v) exp_rgb_raw = bar_ref(p % HT);
      else if (rgb_mode == 0) exp_rgb_raw = {8'(p % HT), 8'(p / HT), 8'hA5};
      else exp_rgb_raw = drv;
   endtask

   // one pixel tick: idle clocks, then pix_en high for one clk
   task automatic tick();
      logic [23:0] drv;
      int p;
      repeat (idle_clks) @(posedge clk);
      @(negedge clk);
      case (rgb_mode)
         0: begin
            if (hist.size() >= PD + 1) begin
               p   = hist[hist.size() - 1 - PD];
               drv = {8'(p % HT), 8'(p / HT), 8'hA5};
            end else begin
               drv = 24'h0;
            end
         end
         1:       drv = 24'hFFFFFF;
         default: drv = 24'($urandom());
      endcase
      pix_en = 1'b1;
      rgb_in = drv;
`ifdef VGA_TEST_PATTERN_EN
      test_mode = tm_v;
`endif
      @(posedge clk);
      model_tick(drv);
      #1;
      pix_en = 1'b0;
   endtask

   // count the clks on which frame_start is seen high
   always @(posedge clk) begin
      #1;
      if (frame_start === 1'b1) fs_clk_cnt++;
   end

   task automatic test_reset();
      rst_n = 1'b0; pix_en = 1'b0; rgb_in = 24'h0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_frames();
      int pulses[$];
      int hs_low = 0, vs_low = 0, vis = 0;
      rgb_mode = 0; idle_clks = 1; fs_clk_cnt = 0;
      for (int k = 1; k <= 2 * FRAME + PD + 1; k++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL frame_tick %0d: got %h want %h", k, dut_vec, exp_vec());
         end
         if (frame_start === 1'b1) pulses.push_back(k);
         if (k > PD + 1) begin
            if (vga_hs === 1'b0) hs_low++;
            if (vga_vs === 1'b0) vs_low++;
            if (vga_blank_n === 1'b1) vis++;
         end
      end
      n_checks++;
      if (pulses.size() != 3) begin
         n_fail++;
         $display("FAIL frame_pulse_count: got %0d want 3", pulses.size());
      end else begin
         n_checks++;
         if ((pulses[1] - pulses[0] != FRAME) || (pulses[2] - pulses[1] != FRAME)) begin
            n_fail++;
            $display("FAIL frame_period: got %0d,%0d want %0d", pulses[1] - pulses[0],
                     pulses[2] - pulses[1], FRAME);
         end
      end
      n_checks++;
      if (fs_clk_cnt != 3) begin
         n_fail++;
         $display("FAIL frame_pulse_width: got %0d clks want 3", fs_clk_cnt);
      end
      n_checks++;
      if (hs_low != 2 * VT * HS) begin
         n_fail++;
         $display("FAIL hsync_ticks: got %0d want %0d", hs_low, 2 * VT * HS);
      end
      n_checks++;
      if (vs_low != 2 * VS * HT) begin
         n_fail++;
         $display("FAIL vsync_ticks: got %0d want %0d", vs_low, 2 * VS * HT);
      end
      n_checks++;
      if (vis != 2 * HA * VA) begin
         n_fail++;
         $display("FAIL visible_ticks: got %0d want %0d", vis, 2 * HA * VA);
      end
   endtask

   task automatic test_blank_white();
      int blanked = 0, leaked = 0;
      rgb_mode = 1;
      for (int k = 0; k < FRAME; k++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL white_tick %0d: got %h want %h", k, dut_vec, exp_vec());
         end
         if (vga_blank_n === 1'b0) begin
            blanked++;
            if ({vga_r, vga_g, vga_b} !== 24'h0) leaked++;
         end
      end
      n_checks++;
      if (blanked != FRAME - HA * VA || leaked != 0) begin
         n_fail++;
         $display("FAIL blank_black: blanked %0d leaked %0d want %0d and 0",
                  blanked, leaked, FRAME - HA * VA);
      end
   endtask

   task automatic test_hold();
      int guard = 0;
      rgb_mode = 2;
      while (pos != 3 * HT + 5 && guard < 2 * FRAME) begin
         tick();
         guard++;
      end
      n_checks++;
      if (pos != 3 * HT + 5) begin
         n_fail++;
         $display("FAIL hold_reach: got pos %0d want %0d", pos, 3 * HT + 5);
      end
      exp_fs = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL hold_clk %0d: got %h want %h", c, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      rgb_mode = 2; idle_clks = 1;
      while (pos != 5 * HT + 10 && guard < 2 * FRAME) begin
         tick();
         guard++;
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_async: got %h want %h", dut_vec, exp_vec());
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_hold: got %h want %h", dut_vec, exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL restart_tick %0d: got %h want %h", k, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      rgb_mode = 2;
      for (int k = 0; k < 400; k++) begin
         idle_clks = $urandom_range(0, 3);
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_tick %0d: got %h want %h", k, dut_vec, exp_vec());
         end
      end
      idle_clks = 1;
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern();
      int hits = 0;
      logic [23:0] want;
      rgb_mode = 2; tm_v = 1'b1;
      for (int k = 0; k < FRAME + HT && hits < 3; k++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL pattern_tick %0d: got %h want %h", k, dut_vec, exp_vec());
         end
         if (k > PD && (hist[0] == 0 || hist[0] == 2 || hist[0] == 14)) begin
            want = (hist[0] == 0) ? 24'hFFFFFF : (hist[0] == 2) ? 24'hFFFF00 : 24'h000000;
            if (hist[0] != 0 || hits == 0) begin
               hits++;
               n_checks++;
               if ({vga_r, vga_g, vga_b} !== want) begin
                  n_fail++;
                  $display("FAIL pattern_bar x=%0d: got %h want %h", hist[0],
                           {vga_r, vga_g, vga_b}, want);
               end
            end
         end
      end
      n_checks++;
      if (hits < 3) begin
         n_fail++;
         $display("FAIL pattern_coverage: got %0d bars want 3", hits);
      end
      tm_v = 1'b0;
   endtask
`endif

   initial begin
      tm_v = 1'b0; idle_clks = 1; rgb_mode = 0; fs_clk_cnt = 0;
      pix_en = 1'b0; rgb_in = 24'h0;
`ifdef VGA_TEST_PATTERN_EN
      test_mode = 1'b0;
`endif
      test_reset();
      test_frames();
      test_blank_white();
      test_hold();
      test_reset_mid();
      test_random();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
